// File: rtl/jimmy_mem_pkg.sv
// Shared types for the dual-core data memory arbiter: FSM states and the
// owner encodings seen on the owner output.
package jimmy_mem_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_e;

   localparam logic [1:0] OWNER_NONE  = 2'b00;
   localparam logic [1:0] OWNER_CORE0 = 2'b01;
   localparam logic [1:0] OWNER_CORE1 = 2'b10;

   function automatic logic [1:0] ownerCode(input logic winnerIsCore1);
      return winnerIsCore1 ? OWNER_CORE1 : OWNER_CORE0;
   endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter. Grants are combinational; the
// last-winner pointer advances only when the parent actually takes a grant.
module rr_arbiter2 (
   input  logic clk,
   input  logic reset,
   input  logic req0_i,
   input  logic req1_i,
   input  logic grantEn_i,
   output logic gnt0_o,
   output logic gnt1_o,
   output logic tie_o
);

   logic lastWinner_q;
   logic lastWinner_d;

   // On a tie, the core that did not win last time gets the grant.
   always_comb begin
      gnt0_o       = req0_i & (~req1_i | lastWinner_q);
      gnt1_o       = req1_i & (~req0_i | ~lastWinner_q);
      tie_o        = req0_i & req1_i;
      lastWinner_d = lastWinner_q;
      if (grantEn_i && (req0_i || req1_i)) begin
         lastWinner_d = gnt1_o;
      end
   end

   // Pointer resets to core 1 so core 0 takes the first tie.
   always_ff @(posedge clk) begin
      if (reset) begin
         lastWinner_q <= 1'b1;
      end else begin
         lastWinner_q <= lastWinner_d;
      end
   end

endmodule

// File: rtl/data_memory_arbiter.sv
// Arbitrates two cores onto one single-port data memory. Each transaction
// takes IDLE -> ACCESS -> DONE, with all outputs registered.
module data_memory_arbiter
   import jimmy_mem_pkg::*;
#(
   parameter int ADDR_W    = 8,
   parameter int DATA_W    = 8,
   parameter int PARTITION = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req0,
   input  logic              req1,
   input  logic              we0,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata0,
   input  logic [DATA_W-1:0] wdata1,
   output logic              ack0,
   output logic              ack1,
   output logic [DATA_W-1:0] rdata0,
   output logic [DATA_W-1:0] rdata1,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [1:0]        owner,
   output logic              contention
);

   state_e            state_q;
   logic              winner_q;
   logic              memEn_q;
   logic              memWe_q;
   logic [ADDR_W-1:0] memAddr_q;
   logic [DATA_W-1:0] memWdata_q;
   logic              ack0_q;
   logic              ack1_q;
   logic [DATA_W-1:0] rdata0_q;
   logic [DATA_W-1:0] rdata1_q;
   logic [1:0]        owner_q;
   logic              contention_q;

   logic              gnt0;
   logic              gnt1;
   logic              arbTie;
   logic              selWe;
   logic [ADDR_W-1:0] selAddr;
   logic [DATA_W-1:0] selWdata;
   logic [ADDR_W-1:0] physAddr;

   rr_arbiter2 u_arb (
      .clk       (clk),
      .reset     (reset),
      .req0_i    (req0),
      .req1_i    (req1),
      .grantEn_i (state_q == IDLE),
      .gnt0_o    (gnt0),
      .gnt1_o    (gnt1),
      .tie_o     (arbTie)
   );

   // Partitioned mode forces the top address bit to the winning core's id.
   always_comb begin
      selWe    = gnt0 ? we0    : we1;
      selAddr  = gnt0 ? addr0  : addr1;
      selWdata = gnt0 ? wdata0 : wdata1;
      if (PARTITION != 0) begin
         physAddr = {gnt1, selAddr[ADDR_W-2:0]};
      end else begin
         physAddr = selAddr;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         winner_q     <= 1'b0;
         memEn_q      <= 1'b0;
         memWe_q      <= 1'b0;
         memAddr_q    <= '0;
         memWdata_q   <= '0;
         ack0_q       <= 1'b0;
         ack1_q       <= 1'b0;
         rdata0_q     <= '0;
         rdata1_q     <= '0;
         owner_q      <= OWNER_NONE;
         contention_q <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               contention_q <= 1'b0;
               if (req0 || req1) begin
                  state_q      <= ACCESS;
                  winner_q     <= gnt1;
                  memEn_q      <= 1'b1;
                  memWe_q      <= selWe;
                  memAddr_q    <= physAddr;
                  memWdata_q   <= selWdata;
                  owner_q      <= ownerCode(gnt1);
                  contention_q <= arbTie;
               end
            end
            ACCESS: begin
               state_q      <= DONE;
               memEn_q      <= 1'b0;
               memWe_q      <= 1'b0;
               contention_q <= 1'b0;
               if (!memWe_q) begin
                  if (winner_q) rdata1_q <= mem_rdata;
                  else          rdata0_q <= mem_rdata;
               end
               ack0_q <= ~winner_q;
               ack1_q <= winner_q;
            end
            DONE: begin
               state_q <= IDLE;
               ack0_q  <= 1'b0;
               ack1_q  <= 1'b0;
               owner_q <= OWNER_NONE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign ack0       = ack0_q;
   assign ack1       = ack1_q;
   assign rdata0     = rdata0_q;
   assign rdata1     = rdata1_q;
   assign mem_en     = memEn_q;
   assign mem_we     = memWe_q;
   assign mem_addr   = memAddr_q;
   assign mem_wdata  = memWdata_q;
   assign owner      = owner_q;
   assign contention = contention_q;

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Randomised plus directed bench for data_memory_arbiter, checked every cycle
// against a transaction-level model with its own copy of memory.
module tb_data_memory_arbiter;

   localparam int PART = 1;

   logic       clk;
   logic       reset;
   logic       req0, req1, we0, we1;
   logic [7:0] addr0, addr1, wdata0, wdata1;
   logic       ack0, ack1, mem_en, mem_we, contention;
   logic [7:0] rdata0, rdata1, mem_addr, mem_wdata, mem_rdata;
   logic [1:0] owner;

   logic [7:0] mem    [256];
   logic [7:0] refMem [256];

   int nCompared = 0;
   int nMismatch = 0;

   // model state: cycles left in the current transaction (0 = free)
   int         mLeft;
   logic       mLast, mWin, mWe;
   logic [7:0] mAddr, mWdata;
   logic       expAck0, expAck1, expEn, expWe, expCont;
   logic [7:0] expRdata0, expRdata1, expAddr, expWdata;
   logic [1:0] expOwner;

   data_memory_arbiter #(.ADDR_W(8), .DATA_W(8), .PARTITION(PART)) dut (
      .clk        (clk),
      .reset      (reset),
      .req0       (req0),
      .req1       (req1),
      .we0        (we0),
      .we1        (we1),
      .addr0      (addr0),
      .addr1      (addr1),
      .wdata0     (wdata0),
      .wdata1     (wdata1),
      .ack0       (ack0),
      .ack1       (ack1),
      .rdata0     (rdata0),
      .rdata1     (rdata1),
      .mem_en     (mem_en),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata),
      .owner      (owner),
      .contention (contention)
   );

   assign mem_rdata = mem[mem_addr];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nCompared++;
      if (got !== exp) begin
         nMismatch++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // One clock: drive inputs at negedge, advance the model, check after the edge.
   task applyStimulus(input logic rst, input logic r0, input logic r1,
                      input logic w0, input logic w1,
                      input logic [7:0] a0, input logic [7:0] a1,
                      input logic [7:0] d0, input logic [7:0] d1);
      logic       doWrite;
      logic [7:0] wa, wd;
      int         pa;
      @(negedge clk);
      reset = rst; req0 = r0; req1 = r1; we0 = w0; we1 = w1;
      addr0 = a0; addr1 = a1; wdata0 = d0; wdata1 = d1;
      doWrite = mem_en && mem_we;
      wa = mem_addr;
      wd = mem_wdata;

      // a write in flight reaches memory on this edge even if reset aborts it
      if (mLeft == 2 && mWe) refMem[mAddr] = mWdata;

      if (rst) begin
         mLeft = 0; mLast = 1'b1;
         expAck0 = 0; expAck1 = 0; expEn = 0; expWe = 0; expCont = 0;
         expRdata0 = 0; expRdata1 = 0; expAddr = 0; expWdata = 0; expOwner = 2'b00;
      end else if (mLeft == 2) begin
         if (!mWe) begin
            if (mWin) expRdata1 = refMem[mAddr];
            else      expRdata0 = refMem[mAddr];
         end
         expEn = 0; expWe = 0; expCont = 0;
         expAck0 = !mWin; expAck1 = mWin;
         mLeft = 1;
      end else if (mLeft == 1) begin
         expAck0 = 0; expAck1 = 0; expOwner = 2'b00;
         mLeft = 0;
      end else begin
         expCont = 0;
         if (r0 || r1) begin
            mWin   = (r0 && r1) ? !mLast : r1;
            mLast  = mWin;
            mWe    = mWin ? w1 : w0;
            mWdata = mWin ? d1 : d0;
            pa     = int'(mWin ? a1 : a0);
            if (PART != 0) pa = (pa % 128) + (mWin ? 128 : 0);
            mAddr  = 8'(pa);
            expEn = 1; expWe = mWe; expAddr = mAddr; expWdata = mWdata;
            expOwner = mWin ? 2'b10 : 2'b01;
            expCont  = r0 && r1;
            mLeft = 2;
         end
      end

      @(posedge clk);
      if (doWrite) mem[wa] = wd;
      #1;
      checkOutput("ack0",       32'(ack0),       32'(expAck0));
      checkOutput("ack1",       32'(ack1),       32'(expAck1));
      checkOutput("mem_en",     32'(mem_en),     32'(expEn));
      checkOutput("mem_we",     32'(mem_we),     32'(expWe));
      checkOutput("mem_addr",   32'(mem_addr),   32'(expAddr));
      checkOutput("mem_wdata",  32'(mem_wdata),  32'(expWdata));
      checkOutput("owner",      32'(owner),      32'(expOwner));
      checkOutput("contention", 32'(contention), 32'(expCont));
      checkOutput("rdata0",     32'(rdata0),     32'(expRdata0));
      checkOutput("rdata1",     32'(rdata1),     32'(expRdata1));
   endtask

   task idleCycle();
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
   endtask

   initial begin
      logic [7:0] v;
      reset = 1'b1; req0 = 0; req1 = 0; we0 = 0; we1 = 0;
      addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
      mLeft = 0; mLast = 1'b1; mWin = 0; mWe = 0; mAddr = 0; mWdata = 0;
      for (int i = 0; i < 256; i++) begin
         v = 8'($urandom);
         mem[i] = v;
         refMem[i] = v;
      end
      mem[0] = 8'd74;   refMem[0] = 8'd74;
      mem[128] = 8'd27; refMem[128] = 8'd27;

      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
      checkOutput("resetAck", 32'({ack0, ack1, mem_en}), 32'h0);

      // core 0 reads mem[0], request pulsed for a single cycle
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
      checkOutput("rd0En",   32'(mem_en),   32'h1);
      checkOutput("rd0Addr", 32'(mem_addr), 32'h0);
      idleCycle();
      checkOutput("rd0Ack",  32'(ack0),   32'h1);
      checkOutput("rd0Data", 32'(rdata0), 32'd74);
      idleCycle();

      // core 1 local address 0 lands in the upper half
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
      checkOutput("rd1Addr", 32'(mem_addr), 32'd128);
      idleCycle();
      checkOutput("rd1Ack",  32'(ack1),   32'h1);
      checkOutput("rd1Data", 32'(rdata1), 32'd27);
      checkOutput("rd1Keep0", 32'(rdata0), 32'd74);
      idleCycle();

      // write then read back through core 0
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd5, 8'h00, 8'hA5, 8'h00);
      idleCycle();
      idleCycle();
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd5, 8'h00, 8'h00, 8'h00);
      idleCycle();
      checkOutput("wrRdBack", 32'(rdata0), 32'hA5);
      idleCycle();

      // both cores requesting continuously from reset release
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
      for (int i = 0; i < 12; i++) begin
         applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'(i), 8'(i + 3), 8'h00, 8'h00);
         if (i == 0) begin
            checkOutput("tieCont",  32'(contention), 32'h1);
            checkOutput("tieFirst", 32'(owner),      32'h1);
         end
         if (i == 3) checkOutput("tieSecond", 32'(owner), 32'h2);
      end
      idleCycle();
      idleCycle();

      // reset during ACCESS aborts the transaction
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h10, 8'h00, 8'h00);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
      checkOutput("abortEn",  32'(mem_en), 32'h0);
      checkOutput("abortAck", 32'({ack0, ack1}), 32'h0);
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h20, 8'h30, 8'h00, 8'h00);
      checkOutput("abortTie", 32'(owner), 32'h1);
      idleCycle();
      idleCycle();

      // randomised traffic with occasional resets
      for (int i = 0; i < 600; i++) begin
         applyStimulus(($urandom_range(0, 49) == 0),
                       ($urandom_range(0, 9) < 6), ($urandom_range(0, 9) < 6),
                       1'($urandom), 1'($urandom),
                       8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
      $finish;
   end

endmodule

// File: doc/data_memory_arbiter.md
DATA_MEMORY_ARBITER -- requirements
Module: data_memory_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 8, address width; DATA_W, default 8, data width; PARTITION, default 1, 1 = each core confined to its own half of memory.
REQ-002 clk  input  1  single clock; all logic on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req0 / req1  input  1  access request from core 0 / core 1.
REQ-005 we0 / we1  input  1  1 = write, 0 = read.
REQ-006 addr0 / addr1  input  ADDR_W  core-local address.
REQ-007 wdata0 / wdata1  input  DATA_W  write data.
REQ-008 ack0 / ack1  output  1  one-cycle pulse marking transaction complete.
REQ-009 rdata0 / rdata1  output  DATA_W  registered read data, valid from the ack cycle onward.
REQ-010 mem_en  output  1  memory access strobe.
REQ-011 mem_we  output  1  memory write enable.
REQ-012 mem_addr  output  ADDR_W  physical memory address.
REQ-013 mem_wdata  output  DATA_W  memory write data.
REQ-014 mem_rdata  input  DATA_W  memory read data, combinational from mem_addr.
REQ-015 owner  output  2  2'b00 = idle, 2'b01 = core 0, 2'b10 = core 1.
REQ-016 contention  output  1  one-cycle pulse when both requests are arbitrated in the same IDLE cycle.

Function
REQ-017 The FSM SHALL have three states, IDLE, ACCESS and DONE, with the following transitions.
- IDLE -> ACCESS when req0 or req1 is high.
- ACCESS -> DONE unconditionally.
- DONE -> IDLE unconditionally.
REQ-018 On IDLE -> ACCESS the block SHALL latch the winner's we, addr and wdata; later requester changes SHALL NOT affect the transaction.
REQ-019 Arbitration SHALL follow these rules.
- Only one request high: that requester wins.
- Both high: the requester that did not win last time wins (round-robin).
- The last-winner pointer updates on every grant.
REQ-020 In ACCESS the block SHALL drive the following registered outputs, with all other cycles mem_en = 0 and mem_we = 0.
- mem_en = 1.
- mem_we = latched we.
- mem_addr = mapped address.
- mem_wdata = latched wdata.
REQ-021 Address mapping SHALL be as follows.
- PARTITION = 1: core 0 maps to {1'b0, addr[ADDR_W-2:0]}; core 1 maps to {1'b1, addr[ADDR_W-2:0]}.
- PARTITION = 0: addr passes through unchanged.
REQ-022 On a read, the block SHALL capture mem_rdata into the winner's rdata register at the end of ACCESS; the loser's rdata SHALL hold.
REQ-023 On a write, both rdata registers SHALL hold their values.
REQ-024 In DONE the winner's ack SHALL be 1 for exactly one cycle; at most one ack SHALL be high in any cycle.
REQ-025 Latency SHALL be 3 cycles: req sampled in IDLE at edge N, ACCESS in cycle N+1, ack in cycle N+2; sustained throughput is one transaction per 3 cycles.
REQ-026 A requester holding req high after its ack SHALL be treated as a new request in the next IDLE cycle.
REQ-027 A requester dropping req during ACCESS or DONE SHALL NOT cancel its transaction; the ack SHALL still issue.
REQ-028 Under continuous requests from both cores, grants SHALL strictly alternate 0, 1, 0, 1, so neither core waits more than 6 cycles.
REQ-029 owner SHALL equal the winner during ACCESS and DONE, and 2'b00 in IDLE.

Reset
REQ-030 While reset is high at a clock edge, the block SHALL set the following state, aborting any in-flight transaction with no ack issued.
- State = IDLE.
- mem_en, mem_we, ack0, ack1 and contention = 0.
- mem_addr, mem_wdata, rdata0 and rdata1 = 0.
- owner = 2'b00.
- Last-winner pointer = core 1, so core 0 wins the first tie.
REQ-031 The first arbitration SHALL occur on the first edge with reset low.

Structure
REQ-032 The FSM state enum and the owner encodings SHALL live in the shared package jimmy_mem_pkg.
REQ-033 Tie-break and pointer logic SHALL be implemented in the sub-module rr_arbiter2.

Verification
REQ-034 The bench SHALL cover these directed scenarios.
- Memory preloaded with mem[0] = 74; req0 read, addr0 = 0 -> mem_en with mem_addr = 0 in cycle N+1; ack0 in N+2; rdata0 = 74.
- PARTITION = 1, mem[128] = 27; req1 read, addr1 = 0 -> mem_addr = 128; ack1; rdata1 = 27; rdata0 unchanged.
- req0 and req1 both high from reset release -> contention pulse; grant order 0, 1, 0, 1; ack spacing 3 cycles.
- req0 write, addr0 = 5, wdata0 = 8'hA5, followed by req0 read of addr0 = 5 -> rdata0 = 8'hA5.
- reset asserted during ACCESS -> no ack; mem_en = 0 next cycle; next tie goes to core 0.
- req0 pulsed for one cycle only -> ack0 still issues at N+2.
